add_recover: RTL and testbench



---
 rtl/add_recover.sv | 112 +++++++++++
 tb/tb_add_recover.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/add_recover.sv
// add_recover: recovers unsigned A = C - B from an add-block sum, range-checks it
// and counts out-of-range results. Define ADD_RECOVER_SAT_EN to clamp instead of wrap.
module add_recover #(
    parameter int unsigned A_W   = 21,
    parameter int unsigned B_W   = 18,
    parameter int unsigned C_W   = 23,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [C_W-1:0]   c_in,
    input  logic [B_W-1:0]   b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [A_W-1:0]   a_out,
    output logic             a_err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned D_W = C_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s1_valid_q, s1_valid_d;
    logic [D_W-1:0]   diff_q, diff_d;
    logic             s2_valid_q, s2_valid_d;
    logic [A_W-1:0]   a_out_q, a_out_d;
    logic             a_err_q, a_err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             s2_load;
    logic             in_xfer;
    logic             out_xfer;
    logic             in_range;
    logic [D_W-1:0]   c_sx;
    logic [D_W-1:0]   b_sx;
    logic [A_W-1:0]   a_next;

    // Handshake, stage-1 subtract, stage-2 range check and saturating error count.
    always_comb begin
        c_sx     = {c_in[C_W-1], c_in};
        b_sx     = {{(D_W - B_W){b_in[B_W-1]}}, b_in};
        s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
        in_ready = ~rst & (~s1_valid_q | s2_load);
        in_xfer  = in_valid & in_ready;
        out_xfer = s2_valid_q & out_ready;
        // In range iff non-negative and no bits set above the A field.
        in_range = ~diff_q[D_W-1] & (diff_q[D_W-2:A_W] == '0);
`ifdef ADD_RECOVER_SAT_EN
        if (in_range) begin
            a_next = diff_q[A_W-1:0];
        end else if (diff_q[D_W-1]) begin
            a_next = '0;
        end else begin
            a_next = '1;
        end
`else
        a_next = diff_q[A_W-1:0];
`endif

        s1_valid_d = s1_valid_q;
        diff_d     = diff_q;
        s2_valid_d = s2_valid_q;
        a_out_d    = a_out_q;
        a_err_d    = a_err_q;
        err_cnt_d  = err_cnt_q;

        if (s2_load) begin
            s1_valid_d = 1'b0;
        end
        if (in_xfer) begin
            s1_valid_d = 1'b1;
            diff_d     = c_sx - b_sx;
        end
        if (out_xfer) begin
            s2_valid_d = 1'b0;
        end
        if (s2_load) begin
            s2_valid_d = 1'b1;
            a_out_d    = a_next;
            a_err_d    = ~in_range;
        end
        if (out_xfer & a_err_q & (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            diff_q     <= '0;
            s2_valid_q <= 1'b0;
            a_out_q    <= '0;
            a_err_q    <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            diff_q     <= diff_d;
            s2_valid_q <= s2_valid_d;
            a_out_q    <= a_out_d;
            a_err_q    <= a_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign a_out     = a_out_q;
    assign a_err     = a_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_add_recover.sv
// Scoreboard bench for add_recover; a small error counter (CNT_W=2) exercises saturation.
module tb_add_recover;

    localparam int unsigned A_W   = 21;
    localparam int unsigned B_W   = 18;
    localparam int unsigned C_W   = 23;
    localparam int unsigned CNT_W = 2;
    localparam longint      A_MAX = (longint'(1) << A_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [C_W-1:0]   c_in = '0;
    logic [B_W-1:0]   b_in = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [A_W-1:0]   a_out;
    logic             a_err;
    logic [CNT_W-1:0] err_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int ready_mode = 0;          // 0: always ready, 1: random, 2: never ready

    logic [A_W:0]     exp_q[$];  // {err, a}
    int               cnt_model = 0;
    bit               cnt_chk = 0;
    bit               post_rst = 0;
    bit               prev_stall = 0;
    logic [A_W-1:0]   prev_a;
    logic             prev_err;

    add_recover #(.A_W(A_W), .B_W(B_W), .C_W(C_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .c_in(c_in), .b_in(b_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .a_out(a_out), .a_err(a_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    function automatic logic [A_W:0] model(input longint c, input longint b);
        longint d;
        logic   err;
        logic [A_W-1:0] a;
        d   = c - b;
        err = (d < 0) || (d > A_MAX);
        a   = A_W'(d);
`ifdef ADD_RECOVER_SAT_EN
        if (d < 0) a = '0;
        else if (d > A_MAX) a = '1;
`endif
        return {err, a};
    endfunction

    // out_ready driver
    initial begin
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 9) < 6);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        logic [A_W:0] e;
        if (rst) begin
            exp_q.delete();
            cnt_model  = 0;
            cnt_chk    = 0;
            post_rst   = 1;
            prev_stall = 0;
        end else begin
            if (post_rst) begin
                check("rst_out_valid", 32'(out_valid), 0);
                check("rst_err_cnt", 32'(err_cnt), 0);
                post_rst = 0;
            end
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 1);
                check("stall_a_out", 32'(a_out), 32'(prev_a));
                check("stall_a_err", 32'(a_err), 32'(prev_err));
            end
            if (cnt_chk) begin
                check("err_cnt", 32'(err_cnt), 32'(cnt_model));
                cnt_chk = 0;
            end
            if (exp_q.size() == 2 && !out_ready)
                check("backpressure_in_ready", 32'(in_ready), 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("a_out", 32'(a_out), 32'(e[A_W-1:0]));
                    check("a_err", 32'(a_err), 32'(e[A_W]));
                    if (a_err && cnt_model < 3) cnt_model++;
                    cnt_chk = 1;
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(longint'($signed(c_in)), longint'($signed(b_in))));
            prev_stall = out_valid && !out_ready;
            prev_a     = a_out;
            prev_err   = a_err;
        end
    end

    task automatic send(input longint c, input longint b);
        bit done = 0;
        in_valid = 1'b1;
        c_in     = C_W'(c);
        b_in     = B_W'(b);
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk); #1;
        end
        if (!done) check("send_timeout", 1, 0);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int i = 0;
        while (exp_q.size() != 0 && i < 500) begin
            @(negedge clk);
            i++;
        end
        check("drain_empty", 32'(exp_q.size()), 0);
        @(posedge clk); #1;
    endtask

    task automatic reset_cycles(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        reset_cycles(3);
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_a_out", 32'(a_out), 0);
        check("reset_a_err", 32'(a_err), 0);
        check("reset_err_cnt", 32'(err_cnt), 0);
        check("reset_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;

        // Basic recovery with latency: driven after edge N, captured at N+1, visible after N+2.
        in_valid = 1'b1; c_in = C_W'(100); b_in = B_W'(-5);
        @(negedge clk);
        check("t1_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("t1_valid_early", 32'(out_valid), 0);
        @(negedge clk);
        check("t1_valid_on_time", 32'(out_valid), 1);
        check("t1_a_out_105", 32'(a_out), 105);
        @(posedge clk); #1;
        drain();

        // Boundaries and negative result.
        send(2097151, 0);
        send(2097152, 0);
        send(-1, 0);
        drain();

        // Streaming under random backpressure.
        ready_mode = 1;
        for (int a = 0; a < 80; a++) send(a - 3, -3);
        drain();
        ready_mode = 0;
        @(posedge clk); #1;

        // Counter saturation from a clean count.
        reset_cycles(1);
        for (int k = 0; k < 5; k++) send(-10 - k, 0);
        drain();
        @(negedge clk);
        check("sat_err_cnt", 32'(err_cnt), 3);
        @(posedge clk); #1;

        // Reset with two items in flight.
        ready_mode = 2;
        @(posedge clk); #1;
        send(50, 1);
        send(60, 2);
        @(negedge clk);
        check("t6_full_in_ready", 32'(in_ready), 0);
        check("t6_full_valid", 32'(out_valid), 1);
        @(posedge clk); #1;
        reset_cycles(1);
        ready_mode = 0;
        @(posedge clk); #1;
        send(10, 3);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
